bcd_to_bin: RTL and testbench



---
 rtl/bcd_pkg.sv | 41 ++++
 rtl/bcd_nib_corr.sv | 21 ++
 rtl/bcd_to_bin.sv | 147 ++++++++++++++
 tb/tb_bcd_to_bin.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared sizing constants, state encoding and a digit-validity
//            helper for the iterative BCD-to-binary converter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam int DIGITS = 6;               // BCD digits accepted per conversion
  localparam int BIN_W  = 20;              // binary result width
  localparam int BCD_W  = 4 * DIGITS;      // packed BCD field width
  localparam int ITER   = BIN_W;           // one result bit per iteration
  localparam int SR_W   = BCD_W + BIN_W;   // combined {bcd, bin} shift register
  localparam int CNT_W  = $clog2(ITER);    // iteration counter width

  localparam logic [3:0] BCD_ADJ = 4'd3;   // amount removed from a large nibble
  localparam logic [3:0] BCD_THR = 4'd8;   // nibble value that needs adjusting
  localparam logic [3:0] BCD_MAX = 4'd9;   // largest legal BCD digit

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  // True when any nibble of the packed digit field holds A..F.
  function automatic logic bcd_has_bad(input logic [BCD_W-1:0] digits);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits[4*i +: 4] > BCD_MAX) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_nib_corr.sv
`default_nettype none
// ============================================================================
// Module   : bcd_nib_corr
// Purpose  : Per-digit correction for reverse double-dabble. After a right
//            shift, a nibble that reached 8 or more carried a borrowed "10"
//            worth 16/2 = 8 instead of 5, so 3 is removed to restore BCD.
// Ports    : nib_i  [3:0]  shifted BCD nibble
//            nib_o  [3:0]  corrected nibble
// Revision : 1.0 - initial release
// ============================================================================
module bcd_nib_corr
  import bcd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= BCD_THR) ? (nib_i - BCD_ADJ) : nib_i;

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_bin
// Purpose  : Iterative six-digit BCD to 20-bit binary converter using reverse
//            double-dabble, one result bit per clock. Accepts digits with a
//            valid/ready handshake and signals each result with a one-cycle
//            out_valid pulse; data and err hold until the next result.
// Ports    : sys_clk    in   system clock, rising edge
//            sys_rst_n  in   asynchronous active-low reset
//            in_valid   in   digits present
//            in_ready   out  converter idle, digits accepted on this edge
//            unit..h_tho in  BCD digits 10^0 .. 10^5
//            data [19:0] out binary result (0 when err)
//            out_valid  out  one-cycle result strobe
//            err        out  last accepted set had a digit above 9
// Revision : 1.0 - initial release
// ============================================================================
module bcd_to_bin
  import bcd_pkg::*;
(
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       unit,
  input  logic [3:0]       ten,
  input  logic [3:0]       hun,
  input  logic [3:0]       tho,
  input  logic [3:0]       t_tho,
  input  logic [3:0]       h_tho,
  output logic [BIN_W-1:0] data,
  output logic             out_valid,
  output logic             err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  state_e             state_q,     state_d;
  logic [SR_W-1:0]    sr_q,        sr_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               err_pend_q,  err_pend_d;
  logic [BIN_W-1:0]   data_q,      data_d;
  logic               err_q,       err_d;
  logic               out_valid_q, out_valid_d;

  logic [BCD_W-1:0]   w_digits;
  logic               w_bad;
  logic [SR_W-1:0]    w_shift;
  logic [BCD_W-1:0]   w_corr;
  logic [SR_W-1:0]    w_iter;

  // Most significant digit sits at the top of the BCD field.
  assign w_digits = {h_tho, t_tho, tho, hun, ten, unit};
  assign w_bad    = bcd_has_bad(w_digits);

  // One iteration: shift the whole register right (BCD LSB drops into the
  // binary MSB), then fix up every BCD nibble.
  assign w_shift = sr_q >> 1;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
      bcd_nib_corr u_corr (
        .nib_i (w_shift[BIN_W + 4*gi +: 4]),
        .nib_o (w_corr[4*gi +: 4])
      );
    end
  endgenerate

  assign w_iter = {w_corr, w_shift[BIN_W-1:0]};

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      sr_q        <= '0;
      cnt_q       <= '0;
      err_pend_q  <= 1'b0;
      data_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      err_pend_q  <= err_pend_d;
      data_q      <= data_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    err_pend_d  = err_pend_q;
    data_d      = data_q;
    err_d       = err_q;
    out_valid_d = 1'b0;
    in_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          sr_d       = {w_digits, {BIN_W{1'b0}}};
          err_pend_d = w_bad;
          cnt_d      = '0;
          state_d    = CONV;
        end
      end

      CONV: begin
        sr_d  = w_iter;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // The binary field is complete after this last shift; result
          // registers update only here so they stay stable in between.
          data_d      = err_pend_q ? '0 : w_iter[BIN_W-1:0];
          err_d       = err_pend_q;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data      = data_q;
  assign err       = err_q;
  assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_bin
// Purpose  : Directed self-checking bench for bcd_to_bin. Digit sets are
//            packed {h_tho,t_tho,tho,hun,ten,unit}; expected binary values
//            are hand-computed decimal conversions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

  logic        sys_clk;
  logic        sys_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] dig_v;
  logic [19:0] data;
  logic        out_valid;
  logic        err;

  int n_total;
  int n_bad;

  bcd_to_bin u_dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .unit      (dig_v[3:0]),
    .ten       (dig_v[7:4]),
    .hun       (dig_v[11:8]),
    .tho       (dig_v[15:12]),
    .t_tho     (dig_v[19:16]),
    .h_tho     (dig_v[23:20]),
    .data      (data),
    .out_valid (out_valid),
    .err       (err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge while the converter should be idle; returns
  // right after the accepting edge.
  task automatic start(input logic [23:0] dig);
    check("ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dig_v    = dig;
    @(posedge sys_clk);
  endtask

  // Follows a conversion from the accept edge to the return to IDLE.
  // hold=1 keeps in_valid high and presents nxt for a back-to-back accept.
  task automatic finish_conv(input string tag, input logic [19:0] exp_d,
                             input logic exp_e, input logic hold,
                             input logic [23:0] nxt);
    int          early;
    logic [19:0] d_prev;
    logic        e_prev;
    d_prev = data;
    e_prev = err;
    #1;
    if (hold) begin
      dig_v = nxt;
    end else begin
      in_valid = 1'b0;
      dig_v    = 24'hAAAAAA;   // must be ignored after the accept edge
    end
    early = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge sys_clk);
      if (out_valid !== 1'b0) early++;
      if (in_ready  !== 1'b0) early++;
      if (data !== d_prev || err !== e_prev) early++;
    end
    check({tag, "_quiet_during_conv"}, early, 32'd0);
    @(negedge sys_clk);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"},      {12'd0, data},      {12'd0, exp_d});
    check({tag, "_err"},       {31'd0, err},       {31'd0, exp_e});
    check({tag, "_busy_in_done"}, {31'd0, in_ready}, 32'd0);
    @(negedge sys_clk);
    check({tag, "_pulse_end"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_data_held"}, {12'd0, data},      {12'd0, exp_d});
    check({tag, "_err_held"},  {31'd0, err},       {31'd0, exp_e});
  endtask

  initial begin
    int pulses;
    n_total   = 0;
    n_bad     = 0;
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    dig_v     = 24'h000000;

    // Reset held, then released with no request.
    repeat (3) @(negedge sys_clk);
    check("rst_data",  {12'd0, data},      32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_err",   {31'd0, err},       32'd0);
    check("rst_ready", {31'd0, in_ready},  32'd1);
    sys_rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || data !== 20'd0 || err !== 1'b0)
        pulses++;
    end
    check("idle_after_rst", pulses, 32'd0);

    // 987360
    start(24'h987360);
    finish_conv("c987360", 20'hF10E0, 1'b0, 1'b0, 24'h0);

    // Back-to-back with in_valid held: 125479 then 000489.
    start(24'h125479);
    finish_conv("c125479", 20'h1EA27, 1'b0, 1'b1, 24'h000489);
    start(24'h000489);
    finish_conv("c000489", 20'h001E9, 1'b0, 1'b0, 24'h0);

    // Boundaries.
    start(24'h999999);
    finish_conv("c999999", 20'hF423F, 1'b0, 1'b0, 24'h0);
    start(24'h000000);
    finish_conv("c000000", 20'h00000, 1'b0, 1'b0, 24'h0);
    start(24'h000001);
    finish_conv("c000001", 20'h00001, 1'b0, 1'b0, 24'h0);

    // Invalid top digit, then a valid set clears err.
    start(24'hA45162);
    finish_conv("cbad", 20'h00000, 1'b1, 1'b0, 24'h0);
    start(24'h000001);
    finish_conv("cclr", 20'h00001, 1'b0, 1'b0, 24'h0);

    // Reset ten cycles into a conversion.
    start(24'h999999);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("abort_data",  {12'd0, data},      32'd0);
    check("abort_err",   {31'd0, err},       32'd0);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_ready", {31'd0, in_ready},  32'd1);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge sys_clk);
      if (out_valid !== 1'b0) pulses++;
    end
    check("abort_no_pulse", pulses, 32'd0);
    check("abort_data_zero", {12'd0, data}, 32'd0);
    start(24'h045162);
    finish_conv("c045162", 20'h0B06A, 1'b0, 1'b0, 24'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
